rc5_host_if: RTL

Host-side driver of the RC5 core's external interface. It accepts a byte stream carrying a header, an optional key and one data block, and writes the key bytes into the core's key RAM port. It then drives the block words and a cipher or decipher start, waits for done, and returns the result words as a byte stream. It sits between a byte-wide host link (UART/FIFO) and the RC5 top.

---
 rtl/rc5_pkg.sv | 20 ++
 rtl/rc5_word_pack.sv | 52 +++++
 rtl/rc5_host_if.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/rc5_pkg.sv
// RC5 host interface shared definitions.
// Default word/key sizing, header field positions and FSM encoding.
package rc5_pkg;

  localparam int W = 16;
  localparam int U = W / 8;
  localparam int B = 16;

  localparam int HDR_OP  = 0;
  localparam int HDR_KEY = 1;

  typedef enum logic [2:0] {
    IDLE,
    KEY,
    DATA,
    RUN,
    SEND
  } state_e;

endpackage

// File: rtl/rc5_word_pack.sv
// Two-word <-> byte stream converter for the RC5 host link.
// One byte index serves both assembling (push_i) and serializing (adv_i).
module rc5_word_pack #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [7:0]   byte_i,
  input  logic         load_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         adv_i,
  output logic [W-1:0] a_o,
  output logic [W-1:0] b_o,
  output logic [7:0]   byte_o,
  output logic         last_o
);

  localparam int N  = 2 * (W / 8);
  localparam int IW = $clog2(N);

  logic [IW-1:0]  idx_q, idx_d;
  logic [2*W-1:0] ab_q, ab_d;

  // A occupies the low half so byte order is A lo..hi, then B lo..hi.
  assign last_o = (idx_q == IW'(N - 1));
  assign byte_o = ab_q[8*idx_q +: 8];
  assign a_o    = ab_q[W-1:0];
  assign b_o    = ab_q[2*W-1:W];

  always_comb begin
    idx_d = idx_q;
    ab_d  = ab_q;
    if (load_i) ab_d = {b_i, a_i};
    if (push_i) ab_d[8*idx_q +: 8] = byte_i;
    if (push_i || adv_i) begin
      idx_d = last_o ? '0 : idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      ab_q  <= '0;
    end else begin
      idx_q <= idx_d;
      ab_q  <= ab_d;
    end
  end

endmodule

// File: rtl/rc5_host_if.sv
// Byte-stream host driver for the RC5 core: key load, block run, result.
// Define RC5_TIMEOUT_EN to add a RUN watchdog of TIMEOUT_CYCLES.
module rc5_host_if #(
  parameter int W              = rc5_pkg::W,
  parameter int B              = rc5_pkg::B,
  parameter int B_LENGTH       = $clog2(B),
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          iByte,
  input  logic                iByteValid,
  output logic                oByteReady,
  output logic [7:0]          oByte,
  output logic                oByteValid,
  input  logic                iByteReady,
  output logic [7:0]          oKey_sub_i,
  output logic [B_LENGTH-1:0] oKey_address,
  output logic                oWen,
  output logic [W-1:0]        oA,
  output logic [W-1:0]        oB,
  output logic                oStartCipher,
  output logic                oStartDecipher,
  input  logic [W-1:0]        iA_res,
  input  logic [W-1:0]        iB_res,
  input  logic                iDone,
  output logic                oErr,
  output logic                oBusy
);

  import rc5_pkg::*;

  state_e              state_q;
  logic                op_q, key_loaded_q, rdy_q;
  logic                wen_q, err_q, stc_q, std_q;
  logic [B_LENGTH-1:0] kidx_q, kaddr_q;
  logic [7:0]          kbyte_q;

  logic accept, take, cap, in_push;
  logic in_last, out_last, tmo_hit;

  logic [W-1:0] unused_a, unused_b;
  logic [7:0]   unused_byte;

  assign accept  = iByteValid & rdy_q;
  assign take    = oByteValid & iByteReady;
  assign in_push = accept & (state_q == DATA);
  assign cap     = (state_q == RUN) & iDone;

  assign oByteReady     = rdy_q;
  assign oByteValid     = (state_q == SEND);
  assign oBusy          = (state_q != IDLE);
  assign oWen           = wen_q;
  assign oKey_address   = kaddr_q;
  assign oKey_sub_i     = kbyte_q;
  assign oStartCipher   = stc_q;
  assign oStartDecipher = std_q;
  assign oErr           = err_q;

`ifdef RC5_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_q;

  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= '0;
    end else if (state_q != RUN) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TW'(1);
    end
  end
`else
  localparam int unused_tmo = TIMEOUT_CYCLES;

  assign tmo_hit = 1'b0;
`endif

  rc5_word_pack #(.W(W)) u_in (
    .clk    (clk),
    .rst_n  (rst),
    .push_i (in_push),
    .byte_i (iByte),
    .load_i (1'b0),
    .a_i    ('0),
    .b_i    ('0),
    .adv_i  (1'b0),
    .a_o    (oA),
    .b_o    (oB),
    .byte_o (unused_byte),
    .last_o (in_last)
  );

  rc5_word_pack #(.W(W)) u_out (
    .clk    (clk),
    .rst_n  (rst),
    .push_i (1'b0),
    .byte_i (8'h00),
    .load_i (cap),
    .a_i    (iA_res),
    .b_i    (iB_res),
    .adv_i  (take),
    .a_o    (unused_a),
    .b_o    (unused_b),
    .byte_o (oByte),
    .last_o (out_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      op_q         <= 1'b0;
      key_loaded_q <= 1'b0;
      rdy_q        <= 1'b0;
      wen_q        <= 1'b0;
      err_q        <= 1'b0;
      stc_q        <= 1'b0;
      std_q        <= 1'b0;
      kidx_q       <= '0;
      kaddr_q      <= '0;
      kbyte_q      <= '0;
    end else begin
      wen_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          rdy_q <= 1'b1;
          if (accept) begin
            op_q   <= iByte[HDR_OP];
            kidx_q <= '0;
            if (iByte[HDR_KEY]) begin
              state_q <= KEY;
            end else if (key_loaded_q) begin
              state_q <= DATA;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        KEY: begin
          if (accept) begin
            wen_q   <= 1'b1;
            kaddr_q <= kidx_q;
            kbyte_q <= iByte;
            kidx_q  <= kidx_q + B_LENGTH'(1);
            if (kidx_q == B_LENGTH'(B - 1)) begin
              key_loaded_q <= 1'b1;
              state_q      <= DATA;
            end
          end
        end
        DATA: begin
          if (accept && in_last) begin
            state_q <= RUN;
            rdy_q   <= 1'b0;
            stc_q   <= ~op_q;
            std_q   <= op_q;
          end
        end
        RUN: begin
          if (iDone) begin
            stc_q   <= 1'b0;
            std_q   <= 1'b0;
            state_q <= SEND;
          end else if (tmo_hit) begin
            stc_q   <= 1'b0;
            std_q   <= 1'b0;
            err_q   <= 1'b1;
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        SEND: begin
          if (take && out_last) begin
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
